amp_fade_ctrl: RTL and testbench

AMP_FADE_CTRL -- requirements
Module: amp_fade_ctrl

---
 rtl/amp_ctrl_pkg.sv | 24 ++
 rtl/amp_fade_ctrl_tick_div.sv | 29 ++
 rtl/amp_fade_ctrl.sv | 94 +++++++++
 tb/tb_amp_fade_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/amp_ctrl_pkg.sv
// Shared constants, state codes and step helpers for the amplitude fade controller.
package amp_ctrl_pkg;

  localparam logic [1:0] AMP_FULL = 2'b00;
  localparam logic [1:0] AMP_MIN  = 2'b11;

  typedef logic [0:0] fade_state_t;
  localparam fade_state_t ST_IDLE = 1'b0;
  localparam fade_state_t ST_FADE = 1'b1;

  // dir = 1 fades out toward the quietest code, dir = 0 fades back in to full.
  function automatic logic [1:0] fade_target(input logic dir);
    return dir ? AMP_MIN : AMP_FULL;
  endfunction

  // One code toward the target, saturating so the code can never wrap.
  function automatic logic [1:0] step_toward(input logic [1:0] amp, input logic dir);
    if (dir)
      return (amp == AMP_MIN) ? AMP_MIN : amp + 2'd1;
    else
      return (amp == AMP_FULL) ? AMP_FULL : amp - 2'd1;
  endfunction

endpackage

// File: rtl/amp_fade_ctrl_tick_div.sv
// Dwell divider: counts ticks up to limit, then strobes wrap and restarts from zero.
module tick_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;

  assign wrap = tick && !clear && (count_reg == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= (count_reg == limit) ? '0 : count_reg + ONE;
    end
  end

endmodule

// File: rtl/amp_fade_ctrl.sv
// Steps a 2-bit amplitude-select code toward full or minimum, one code every
// (dwell+1) sample ticks, with abort, direct load and a completion pulse.
module amp_fade_ctrl
  import amp_ctrl_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  input  logic               load,
  input  logic [1:0]         manual_amp,
  output logic [1:0]         amp,
  output logic               busy,
  output logic               done
);

  fade_state_t        state_reg, state_next;
  logic [1:0]         amp_reg, amp_next;
  logic               done_reg, done_next;
  logic               busy_reg;
  logic               dir_reg, dir_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic               step_en;

  // Counter is held cleared while idle, so every fade starts from a zero count.
  tick_div #(.W(DWELL_W)) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (sample_tick && (state_reg == ST_FADE)),
    .clear (state_reg == ST_IDLE),
    .limit (dwell_reg),
    .wrap  (step_en)
  );

  always_comb begin
    state_next = state_reg;
    amp_next   = amp_reg;
    done_next  = 1'b0;
    dir_next   = dir_reg;
    dwell_next = dwell_reg;
    if (state_reg == ST_IDLE) begin
      if (start) begin
        if (amp_reg == fade_target(dir)) begin
          done_next = 1'b1;
        end else begin
          state_next = ST_FADE;
          dir_next   = dir;
          dwell_next = dwell;
        end
      end else if (load) begin
        amp_next = manual_amp;
      end
    end else begin
      // abort outranks a coincident step; the step is simply dropped
      if (abort) begin
        state_next = ST_IDLE;
      end else if (step_en) begin
        amp_next = step_toward(amp_reg, dir_reg);
        if (amp_next == fade_target(dir_reg)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      amp_reg   <= AMP_FULL;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      dir_reg   <= 1'b0;
      dwell_reg <= '0;
    end else begin
      state_reg <= state_next;
      amp_reg   <= amp_next;
      done_reg  <= done_next;
      busy_reg  <= (state_next == ST_FADE);
      dir_reg   <= dir_next;
      dwell_reg <= dwell_next;
    end
  end

  assign amp  = amp_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_amp_fade_ctrl.sv
// Scoreboard bench for amp_fade_ctrl: a cycle model queues expected outputs, directed checks cover the listed scenarios.
module tb_amp_fade_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic          abort = 1'b0;
  logic          load = 1'b0;
  logic [1:0]    manual_amp = 2'b00;
  logic [1:0]    amp;
  logic          busy;
  logic          done;

  amp_fade_ctrl #(.DWELL_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .start       (start),
    .dir         (dir),
    .dwell       (dwell),
    .abort       (abort),
    .load        (load),
    .manual_amp  (manual_amp),
    .amp         (amp),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] amp;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  // reference model state
  logic [1:0]    m_amp   = 2'b00;
  logic          m_fade  = 1'b0;
  logic          m_dir   = 1'b0;
  logic          m_done  = 1'b0;
  logic [DW-1:0] m_dwell = '0;
  logic [DW-1:0] m_cnt   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, n_cyc);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    exp_t       e;
    logic [1:0] tgt;
    if (!rst_n) begin
      m_amp = 2'b00; m_fade = 1'b0; m_dir = 1'b0; m_done = 1'b0; m_dwell = '0; m_cnt = '0;
    end else begin
      m_done = 1'b0;
      if (!m_fade) begin
        if (start) begin
          tgt = dir ? 2'b11 : 2'b00;
          if (m_amp == tgt) m_done = 1'b1;
          else begin
            m_fade = 1'b1; m_dir = dir; m_dwell = dwell; m_cnt = '0;
          end
        end else if (load) begin
          m_amp = manual_amp;
        end
      end else if (abort) begin
        m_fade = 1'b0;
      end else if (sample_tick) begin
        if (m_cnt == m_dwell) begin
          m_cnt = '0;
          m_amp = m_dir ? m_amp + 2'd1 : m_amp - 2'd1;
          if (m_amp == (m_dir ? 2'b11 : 2'b00)) begin
            m_fade = 1'b0;
            m_done = 1'b1;
          end
        end else begin
          m_cnt = m_cnt + 8'd1;
        end
      end
    end
    e.amp = m_amp; e.busy = m_fade; e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic step_cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    n_cyc++;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      $display("[TB] cyc %0d amp=%b busy=%b done=%b", n_cyc, amp, busy, done);
      check("sb_amp", 32'(amp), 32'(e.amp));
      check("sb_busy", 32'(busy), 32'(e.busy));
      check("sb_done", 32'(done), 32'(e.done));
    end
  endtask

  task automatic drive(input logic t, input logic s, input logic d, input logic [DW-1:0] dw,
                       input logic ab, input logic ld, input logic [1:0] ma);
    sample_tick = t; start = s; dir = d; dwell = dw; abort = ab; load = ld; manual_amp = ma;
    step_cycle();
    sample_tick = 1'b0; start = 1'b0; abort = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    // reset held over two edges
    step_cycle();
    step_cycle();
    check("rst_amp", 32'(amp), 32'(2'b00));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_done", 32'(done), 32'(1'b0));
    rst_n = 1'b1;

    // fade out, dwell=2, tick every cycle
    drive(1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 2'b00);
    check("s1_busy_start", 32'(busy), 32'(1'b1));
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
      check("s1_amp", 32'(amp), 32'(k / 3));
      check("s1_busy", 32'(busy), 32'(k < 9));
      check("s1_done", 32'(done), 32'(k == 9));
    end
    idle(1);
    check("s1_done_once", 32'(done), 32'(1'b0));

    // fade in from 11, dwell=0, tick every 4 cycles
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    for (int j = 1; j <= 3; j++) begin
      idle(3);
      check("s2_hold", 32'(amp), 32'(4 - j));
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
      check("s2_amp", 32'(amp), 32'(3 - j));
      check("s2_done", 32'(done), 32'(j == 3));
    end

    // abort coincident with the step tick from 01
    drive(1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    check("s3_amp01", 32'(amp), 32'(2'b01));
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 2'b00);
    check("s3_abort_amp", 32'(amp), 32'(2'b01));
    check("s3_abort_busy", 32'(busy), 32'(1'b0));
    check("s3_abort_done", 32'(done), 32'(1'b0));
    idle(1);
    check("s3_no_done", 32'(done), 32'(1'b0));

    // already at target, then load ignored mid-fade
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'b11);
    check("s4_load", 32'(amp), 32'(2'b11));
    drive(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 2'b00);
    check("s4_done", 32'(done), 32'(1'b1));
    check("s4_busy", 32'(busy), 32'(1'b0));
    idle(1);
    check("s4_done_clr", 32'(done), 32'(1'b0));
    drive(1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'b10);
    check("s4_load_ign", 32'(amp), 32'(2'b11));
    check("s4_fade_busy", 32'(busy), 32'(1'b1));
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 2'b00);

    // asynchronous reset mid-fade at amp=10
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    check("s5_amp10", 32'(amp), 32'(2'b10));
    #3;
    rst_n = 1'b0;
    #1;
    check("s5_async_amp", 32'(amp), 32'(2'b00));
    check("s5_async_busy", 32'(busy), 32'(1'b0));
    step_cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 2'b00);
    check("s5_restart", 32'(busy), 32'(1'b1));
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    check("s5_end", 32'(amp), 32'(2'b11));

    // start beats load; start during fade ignored
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 2'b11);
    check("s6_amp", 32'(amp), 32'(2'b00));
    check("s6_busy", 32'(busy), 32'(1'b1));
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    check("s6_start_ign", 32'(amp), 32'(2'b01));
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
    check("s6_final", 32'(amp), 32'(2'b11));

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)));
    end

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
